lfsr_hex_streamer: RTL

LFSR_HEX_STREAMER -- requirements
Module: lfsr_hex_streamer

---
 rtl/lfsr_uart_pkg.sv | 17 +
 rtl/hex_to_ascii.sv | 17 +
 rtl/lfsr_hex_streamer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lfsr_uart_pkg.sv
// Shared definitions for the LFSR-to-UART hex streamer: FSM encoding and the
// ASCII constants used when formatting a random word as text.
package lfsr_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEX  = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit conversion.
module hex_to_ascii
    import lfsr_uart_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_0 + {4'd0, nibble_i};
        end else begin
            ascii_o = ASCII_A + {4'd0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/lfsr_hex_streamer.sv
// Streams words from an external LFSR to a UART as uppercase hex text,
// optionally terminated by CR LF, with a valid/ready byte handshake.
module lfsr_hex_streamer
    import lfsr_uart_pkg::*;
#(
    parameter int N         = 16,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [N-1:0] random,
    output logic         lfsr_ena,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic [15:0]  words_sent,
    output state_t       dbg_state_o
);

    // Handshake: a byte moves on a rising edge where tx_valid and tx_ready
    // are both high; while tx_valid is high and tx_ready low, tx_data holds.
    localparam int NIB   = N / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [N-1:0]       shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ena_q, ena_d;
    logic               busy_q, busy_d;
    logic [15:0]        words_sent_q, words_sent_d;

    logic               xfer;
    logic [N-1:0]       nib_word;
    logic [IDX_W-1:0]   nib_idx;
    logic [N-1:0]       nib_shift;
    logic [3:0]         nib_val;
    logic [7:0]         nib_ascii;

    // In IDLE the byte to present is the top nibble of the word being
    // captured; otherwise it is the next lower nibble of the shadow copy.
    always_comb begin
        xfer      = valid_q && tx_ready;
        nib_word  = (state_q == ST_IDLE) ? random : shadow_q;
        nib_idx   = (state_q == ST_IDLE) ? IDX_TOP : (idx_q - IDX_W'(1));
        nib_shift = nib_word >> {nib_idx, 2'b00};
        nib_val   = nib_shift[3:0];
    end

    hex_to_ascii u_hex_to_ascii (
        .nibble_i (nib_val),
        .ascii_o  (nib_ascii)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ena_d        = 1'b0;
        words_sent_d = words_sent_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (run) begin
                    shadow_d = random;
                    idx_d    = IDX_TOP;
                    data_d   = nib_ascii;
                    valid_d  = 1'b1;
                    ena_d    = 1'b1;
                    state_d  = ST_HEX;
                end
            end
            ST_HEX: begin
                if (xfer) begin
                    if (idx_q != '0) begin
                        idx_d  = idx_q - IDX_W'(1);
                        data_d = nib_ascii;
                    end else if (SEND_CRLF) begin
                        data_d  = CR;
                        state_d = ST_CR;
                    end else begin
                        valid_d      = 1'b0;
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_CR: begin
                if (xfer) begin
                    data_d  = LF;
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    valid_d      = 1'b0;
                    words_sent_d = words_sent_q + 16'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            idx_q        <= '0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            ena_q        <= 1'b0;
            busy_q       <= 1'b0;
            words_sent_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ena_q        <= ena_d;
            busy_q       <= busy_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign lfsr_ena    = ena_q;
    assign tx_data     = data_q;
    assign tx_valid    = valid_q;
    assign busy        = busy_q;
    assign words_sent  = words_sent_q;
    assign dbg_state_o = state_q;

endmodule
